// File: rtl/ber_meter_if.sv
// ber_meter_if: stimulus and window-result bundle between link receiver and ber_meter
interface ber_meter_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 32,
    parameter int IDX_W  = 16
);
    logic              clear_i;
    logic              valid_i;
    logic [DATA_W-1:0] sent_data;
    logic [DATA_W-1:0] recv_data;
    logic [CNT_W-1:0]  threshold_i;
    logic              valid_o;
    logic [CNT_W-1:0]  err_count;
    logic              sat_o;
    logic              alarm_o;
    logic [IDX_W-1:0]  window_idx;
    modport master (
        output clear_i, valid_i, sent_data, recv_data, threshold_i,
        input  valid_o, err_count, sat_o, alarm_o, window_idx
    );
    modport slave (
        input  clear_i, valid_i, sent_data, recv_data, threshold_i,
        output valid_o, err_count, sat_o, alarm_o, window_idx
    );
endinterface

// File: rtl/ber_meter.sv
// ber_meter: pipelined XOR/popcount bit-error counter publishing one result per window of valid beats
module ber_meter #(
    parameter int DATA_W = 8,
    parameter int WINDOW = 240_000_000,
    parameter int CNT_W  = 32,
    parameter int IDX_W  = 16
) (
    input logic        CLK,
    input logic        RST,
    ber_meter_if.slave bus
);
    localparam int PC_W = $clog2(DATA_W + 1);
    localparam int BC_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(WINDOW - 1);
    logic [DATA_W-1:0] x1_q, x1_d;
    logic              v1_q, v1_d;
    logic [PC_W-1:0]   pc2_q, pc2_d;
    logic              v2_q, v2_d;
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic              sat_acc_q, sat_acc_d;
    logic [BC_W-1:0]   beat_q, beat_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic              sat_q, sat_d;
    logic              alarm_q, alarm_d;
    logic              vo_q, vo_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W:0]    raw;
    logic [CNT_W-1:0]  sum;
    logic              ovf;
    always_comb begin
        pc2_d = '0;
        for (int i = 0; i < DATA_W; i++) pc2_d = pc2_d + PC_W'(x1_q[i]);
    end
    // One spare carry bit detects the overflow that clamps the accumulator
    assign raw = {1'b0, acc_q} + (CNT_W + 1)'(pc2_q);
    assign ovf = raw[CNT_W];
    assign sum = ovf ? '1 : raw[CNT_W-1:0];
    always_comb begin
        x1_d      = bus.sent_data ^ bus.recv_data;
        v1_d      = bus.valid_i & ~bus.clear_i;
        v2_d      = v1_q & ~bus.clear_i;
        acc_d     = acc_q;
        sat_acc_d = sat_acc_q;
        beat_d    = beat_q;
        idx_d     = idx_q;
        err_d     = err_q;
        sat_d     = sat_q;
        alarm_d   = alarm_q;
        vo_d      = 1'b0;
        if (bus.clear_i) begin
            acc_d     = '0;
            sat_acc_d = 1'b0;
            beat_d    = '0;
            idx_d     = '0;
        end else if (v2_q && beat_q == LAST_BEAT) begin
            err_d     = sum;
            sat_d     = sat_acc_q | ovf;
            alarm_d   = sum > bus.threshold_i;
            idx_d     = idx_q + IDX_W'(1);
            vo_d      = 1'b1;
            acc_d     = '0;
            sat_acc_d = 1'b0;
            beat_d    = '0;
        end else if (v2_q) begin
            acc_d     = sum;
            sat_acc_d = sat_acc_q | ovf;
            beat_d    = beat_q + BC_W'(1);
        end
    end
    always_ff @(posedge CLK) begin
        if (!RST) begin
            x1_q      <= '0;
            v1_q      <= 1'b0;
            pc2_q     <= '0;
            v2_q      <= 1'b0;
            acc_q     <= '0;
            sat_acc_q <= 1'b0;
            beat_q    <= '0;
            err_q     <= '0;
            sat_q     <= 1'b0;
            alarm_q   <= 1'b0;
            vo_q      <= 1'b0;
            idx_q     <= '0;
        end else begin
            x1_q      <= x1_d;
            v1_q      <= v1_d;
            pc2_q     <= pc2_d;
            v2_q      <= v2_d;
            acc_q     <= acc_d;
            sat_acc_q <= sat_acc_d;
            beat_q    <= beat_d;
            err_q     <= err_d;
            sat_q     <= sat_d;
            alarm_q   <= alarm_d;
            vo_q      <= vo_d;
            idx_q     <= idx_d;
        end
    end
    assign bus.valid_o    = vo_q;
    assign bus.err_count  = err_q;
    assign bus.sat_o      = sat_q;
    assign bus.alarm_o    = alarm_q;
    assign bus.window_idx = idx_q;
endmodule

// File: tb/tb_ber_meter.sv
// tb_ber_meter: three ber_meter configurations checked against a queue-based window model plus directed tables
module tb_ber_meter;
    logic        CLK = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        vld = 1'b0;
    logic [15:0] s = '0;
    logic [15:0] r = '0;
    logic [31:0] thr = '0;
    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    always #5 CLK = ~CLK;
    ber_meter_if #(.DATA_W(8),  .CNT_W(32), .IDX_W(16)) b0 ();
    ber_meter_if #(.DATA_W(8),  .CNT_W(4),  .IDX_W(4))  b1 ();
    ber_meter_if #(.DATA_W(16), .CNT_W(8),  .IDX_W(2))  b2 ();
    assign b0.clear_i = clr;
    assign b1.clear_i = clr;
    assign b2.clear_i = clr;
    assign b0.valid_i = vld;
    assign b1.valid_i = vld;
    assign b2.valid_i = vld;
    assign b0.sent_data = s[7:0];
    assign b1.sent_data = s[7:0];
    assign b2.sent_data = s;
    assign b0.recv_data = r[7:0];
    assign b1.recv_data = r[7:0];
    assign b2.recv_data = r;
    assign b0.threshold_i = thr;
    assign b1.threshold_i = thr[3:0];
    assign b2.threshold_i = thr[7:0];
    ber_meter #(.DATA_W(8),  .WINDOW(4), .CNT_W(32), .IDX_W(16)) u0 (.CLK(CLK), .RST(rst_n), .bus(b0.slave));
    ber_meter #(.DATA_W(8),  .WINDOW(3), .CNT_W(4),  .IDX_W(4))  u1 (.CLK(CLK), .RST(rst_n), .bus(b1.slave));
    ber_meter #(.DATA_W(16), .WINDOW(1), .CNT_W(8),  .IDX_W(2))  u2 (.CLK(CLK), .RST(rst_n), .bus(b2.slave));
    logic [63:0] d_vo[3], d_err[3], d_sat[3], d_al[3], d_idx[3];
    assign d_vo[0]  = 64'(b0.valid_o);
    assign d_vo[1]  = 64'(b1.valid_o);
    assign d_vo[2]  = 64'(b2.valid_o);
    assign d_err[0] = 64'(b0.err_count);
    assign d_err[1] = 64'(b1.err_count);
    assign d_err[2] = 64'(b2.err_count);
    assign d_sat[0] = 64'(b0.sat_o);
    assign d_sat[1] = 64'(b1.sat_o);
    assign d_sat[2] = 64'(b2.sat_o);
    assign d_al[0]  = 64'(b0.alarm_o);
    assign d_al[1]  = 64'(b1.alarm_o);
    assign d_al[2]  = 64'(b2.alarm_o);
    assign d_idx[0] = 64'(b0.window_idx);
    assign d_idx[1] = 64'(b1.window_idx);
    assign d_idx[2] = 64'(b2.window_idx);
    // Model: each valid beat becomes an event landing two edges later; a window is WINDOW landed beats
    int P_DW[3]  = '{8, 8, 16};
    int P_WIN[3] = '{4, 3, 1};
    int P_CW[3]  = '{32, 4, 8};
    int P_IW[3]  = '{16, 4, 2};
    typedef struct { int land; int errs; } ev_t;
    ev_t    pq[3][$];
    longint m_total[3], m_err[3];
    int     m_beats[3], m_idx[3];
    bit     m_vo[3], m_sat[3], m_al[3];
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", nm, act, exp, edge_n);
        end
    endtask
    task automatic model_edge();
        longint mx;
        ev_t e;
        for (int i = 0; i < 3; i++) begin
            mx = (longint'(1) << P_CW[i]) - 1;
            if (!rst_n) begin
                pq[i].delete();
                m_total[i] = 0; m_beats[i] = 0; m_vo[i] = 0;
                m_err[i] = 0; m_sat[i] = 0; m_al[i] = 0; m_idx[i] = 0;
            end else if (clr) begin
                pq[i].delete();
                m_total[i] = 0; m_beats[i] = 0; m_vo[i] = 0; m_idx[i] = 0;
            end else begin
                m_vo[i] = 0;
                if (pq[i].size() > 0 && pq[i][0].land == edge_n) begin
                    e = pq[i].pop_front();
                    m_total[i] += e.errs;
                    m_beats[i]++;
                    if (m_beats[i] == P_WIN[i]) begin
                        m_err[i] = (m_total[i] > mx) ? mx : m_total[i];
                        m_sat[i] = m_total[i] > mx;
                        m_al[i] = m_err[i] > (longint'(thr) & mx);
                        m_idx[i] = (m_idx[i] + 1) % (1 << P_IW[i]);
                        m_vo[i] = 1;
                        m_total[i] = 0;
                        m_beats[i] = 0;
                    end
                end
                if (vld) begin
                    e.land = edge_n + 2;
                    e.errs = $countones(32'(s ^ r) & ((32'd1 << P_DW[i]) - 1));
                    pq[i].push_back(e);
                end
            end
        end
    endtask
    task automatic check_model();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("model u%0d.valid_o", i), d_vo[i], 64'(m_vo[i]));
            chk($sformatf("model u%0d.err_count", i), d_err[i], 64'(m_err[i]));
            chk($sformatf("model u%0d.sat_o", i), d_sat[i], 64'(m_sat[i]));
            chk($sformatf("model u%0d.alarm_o", i), d_al[i], 64'(m_al[i]));
            chk($sformatf("model u%0d.window_idx", i), d_idx[i], 64'(m_idx[i]));
        end
    endtask
    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        check_model();
        edge_n++;
    endtask
    typedef struct {
        int n; bit rn, c, v; logic [7:0] rd; logic [31:0] t;
        bit evo; longint eerr; bit esat, eal; int eidx;
    } vec_t;
    vec_t tbl[33];
    int pulses;
    initial begin
        tbl = '{
            '{3, 0,0,0, 8'h00,   5, 0, 0,0,0,0},
            '{1, 1,0,1, 8'h01,   5, 0, 0,0,0,0},
            '{1, 1,0,1, 8'h03,   5, 0, 0,0,0,0},
            '{1, 1,0,1, 8'hFF,   5, 0, 0,0,0,0},
            '{1, 1,0,1, 8'h00,   5, 0, 0,0,0,0},
            '{1, 1,0,0, 8'h00,   5, 0, 0,0,0,0},
            '{1, 1,0,0, 8'h00,   5, 1,11,0,1,1},
            '{1, 1,0,0, 8'h00,   5, 0,11,0,1,1},
            '{1, 1,0,1, 8'h01,   5, 0,11,0,1,1},
            '{2, 1,0,0, 8'h00,   5, 0,11,0,1,1},
            '{1, 1,0,1, 8'h03,   5, 0,11,0,1,1},
            '{2, 1,0,0, 8'h00,   5, 0,11,0,1,1},
            '{1, 1,0,1, 8'hFF,   5, 0,11,0,1,1},
            '{2, 1,0,0, 8'h00,   5, 0,11,0,1,1},
            '{1, 1,0,1, 8'h00,   5, 0,11,0,1,1},
            '{1, 1,0,0, 8'h00,   5, 0,11,0,1,1},
            '{1, 1,0,0, 8'h00,   5, 1,11,0,1,2},
            '{4, 1,0,1, 8'h00,   5, 0,11,0,1,2},
            '{1, 1,0,0, 8'h00,   5, 0,11,0,1,2},
            '{1, 1,0,0, 8'h00,   5, 1, 0,0,0,3},
            '{4, 1,0,1, 8'h01, 100, 0, 0,0,0,3},
            '{1, 1,0,0, 8'h00, 100, 0, 0,0,0,3},
            '{1, 1,0,0, 8'h00,   2, 1, 4,0,1,4},
            '{2, 1,0,1, 8'hFF,   5, 0, 4,0,1,4},
            '{1, 1,1,1, 8'hFF,   5, 0, 4,0,1,0},
            '{4, 1,0,1, 8'h01,   5, 0, 4,0,1,0},
            '{1, 1,0,0, 8'h00,   5, 0, 4,0,1,0},
            '{1, 1,0,0, 8'h00,   5, 1, 4,0,0,1},
            '{2, 1,0,1, 8'hFF,   5, 0, 4,0,0,1},
            '{1, 0,0,1, 8'hFF,   5, 0, 0,0,0,0},
            '{4, 1,0,1, 8'h01,   5, 0, 0,0,0,0},
            '{1, 1,0,0, 8'h00,   5, 0, 0,0,0,0},
            '{1, 1,0,0, 8'h00,   5, 1, 4,0,0,1}
        };
        // Reset then long idle: nothing may pulse
        rst_n = 0;
        for (int k = 0; k < 3; k++) step();
        rst_n = 1;
        pulses = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            pulses += int'(d_vo[0][0]) + int'(d_vo[1][0]) + int'(d_vo[2][0]);
        end
        chk("idle pulses", 64'(pulses), 64'd0);
        chk("idle err_count", d_err[0], 64'd0);
        // Directed windows on the WINDOW=4 instance
        foreach (tbl[j]) begin
            for (int k = 0; k < tbl[j].n; k++) begin
                rst_n = tbl[j].rn; clr = tbl[j].c; vld = tbl[j].v;
                s = '0; r = {tbl[j].rd, tbl[j].rd}; thr = tbl[j].t;
                step();
                chk($sformatf("tbl%0d valid_o", j), d_vo[0], 64'(tbl[j].evo));
                chk($sformatf("tbl%0d err_count", j), d_err[0], 64'(tbl[j].eerr));
                chk($sformatf("tbl%0d sat_o", j), d_sat[0], 64'(tbl[j].esat));
                chk($sformatf("tbl%0d alarm_o", j), d_al[0], 64'(tbl[j].eal));
                chk($sformatf("tbl%0d window_idx", j), d_idx[0], 64'(tbl[j].eidx));
            end
        end
        // Saturation: CNT_W=4, WINDOW=3, 24 errored bits clamp to 15
        clr = 0; vld = 0; rst_n = 0; step(); rst_n = 1;
        thr = 0; s = 16'h00FF; r = '0; vld = 1;
        for (int k = 0; k < 3; k++) step();
        vld = 0; step(); step();
        chk("sat valid_o", d_vo[1], 64'd1);
        chk("sat err_count", d_err[1], 64'd15);
        chk("sat sat_o", d_sat[1], 64'd1);
        s = '0; vld = 1;
        for (int k = 0; k < 3; k++) step();
        vld = 0; step(); step();
        chk("clean valid_o", d_vo[1], 64'd1);
        chk("clean err_count", d_err[1], 64'd0);
        chk("clean sat_o", d_sat[1], 64'd0);
        // WINDOW=1: back-to-back closes
        rst_n = 0; step(); rst_n = 1;
        s = '0; vld = 1;
        r = 16'h0001; step();
        r = 16'hFFFF; step();
        r = 16'h0000; step();
        chk("w1 pulse1", d_vo[2], 64'd1);
        chk("w1 err1", d_err[2], 64'd1);
        chk("w1 idx1", d_idx[2], 64'd1);
        vld = 0; step();
        chk("w1 pulse2", d_vo[2], 64'd1);
        chk("w1 err2", d_err[2], 64'd16);
        chk("w1 idx2", d_idx[2], 64'd2);
        step();
        chk("w1 pulse3", d_vo[2], 64'd1);
        chk("w1 err3", d_err[2], 64'd0);
        chk("w1 idx3", d_idx[2], 64'd3);
        step();
        chk("w1 no pulse", d_vo[2], 64'd0);
        // Randomised traffic against the model
        for (int k = 0; k < 3000; k++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            clr = ($urandom_range(0, 59) == 0);
            vld = ($urandom_range(0, 3) != 0);
            s = 16'($urandom);
            r = ($urandom_range(0, 3) == 0) ? ~s :
                ($urandom_range(0, 1) == 1) ? (s ^ (16'h1 << $urandom_range(0, 15))) : 16'($urandom);
            thr = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 20)) : $urandom;
            step();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
